// File: rtl/zafx_multicycle_core.sv
// zafx_multicycle_core: multi-cycle ZAFx core with internal FSM and valid/ready IN/OUT
// Ports: clk_i/rst_ni (async active-low), imem_addr_o/imem_data_i (instruction ROM),
// dmem_addr_o/dmem_wdata_o/dmem_we_o/dmem_rdata_i (data memory), in_valid_i/in_ready_o/in_data_i,
// out_valid_o/out_ready_i/out_data_o, halted_o, illegal_o (both sticky).
// Build option: define ZAFX_MUL_EN to make R-type funct 0x18 (MUL) legal.
module zafx_multicycle_core #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int PC_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   output logic [PC_W-1:0]   imem_addr_o,
   input  logic [31:0]       imem_data_i,
   output logic [DATA_W-1:0] dmem_addr_o,
   output logic [DATA_W-1:0] dmem_wdata_o,
   output logic              dmem_we_o,
   input  logic [DATA_W-1:0] dmem_rdata_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              halted_o,
   output logic              illegal_o
);
   localparam int RW = $clog2(NREGS);
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                          OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_IN = 6'h3C,
                          OP_OUT = 6'h3D, OP_HALT = 6'h3F;
   localparam logic [5:0] F_SLL = 6'h00, F_MUL = 6'h18, F_ADD = 6'h20, F_SUB = 6'h22,
                          F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, IO_WAIT, HALT} state_t;
   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, out_q, out_d;
   logic              illegal_q, illegal_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [5:0]        op, fn;
   logic [RW-1:0]     rs_idx, rt_idx, rd_idx, rf_waddr;
   logic [DATA_W-1:0] rs_val, rt_val, imm_d, alu, rf_wdata;
   logic [PC_W-1:0]   imm_p, jump;
   logic              r_ok, legal, take, rf_we;
   assign op     = ir_q[31:26];
   assign fn     = ir_q[5:0];
   assign rs_idx = ir_q[21 +: RW];
   assign rt_idx = ir_q[16 +: RW];
   assign rd_idx = ir_q[11 +: RW];
   assign rs_val = regs_q[rs_idx];
   assign rt_val = regs_q[rt_idx];
   assign imm_d  = DATA_W'($signed(ir_q[15:0]));
   assign imm_p  = PC_W'($signed(ir_q[15:0]));
   assign jump   = PC_W'(ir_q[25:0]);
`ifdef ZAFX_MUL_EN
   assign r_ok = fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_MUL};
`else
   assign r_ok = fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL};
`endif
   assign legal = op == OP_R ? r_ok
                : op inside {OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW, OP_IN, OP_OUT, OP_HALT};
   // pc_q already holds pc+1 here, so the taken target is simply pc_q+imm
   assign take = (op == OP_BEQ && a_q == b_q) || (op == OP_BNE && a_q != b_q);
   // non-R opcodes that reach the ALU all need base+offset
   always_comb begin
      alu = a_q + imm_d;
      if (op == OP_R)
         case (fn)
            F_ADD:   alu = a_q + b_q;
            F_SUB:   alu = a_q - b_q;
            F_AND:   alu = a_q & b_q;
            F_OR:    alu = a_q | b_q;
            F_SLT:   alu = DATA_W'($signed(a_q) < $signed(b_q));
            F_SLL:   alu = b_q << ir_q[10:6];
`ifdef ZAFX_MUL_EN
            F_MUL:   alu = a_q * b_q;
`endif
            default: alu = '0;
         endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state_q <= FETCH;
      else         state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE:  state_d = op == OP_HALT ? HALT : (op == OP_IN || op == OP_OUT) ? IO_WAIT : EXEC;
         EXEC:    state_d = ((op == OP_R && r_ok) || op == OP_ADDI) ? WB
                          : (op == OP_LW || op == OP_SW) ? MEM : FETCH;
         MEM:     state_d = op == OP_LW ? WB : FETCH;
         WB:      state_d = FETCH;
         IO_WAIT: state_d = (op == OP_IN ? in_valid_i : out_ready_i) ? FETCH : IO_WAIT;
         default: state_d = HALT;
      endcase
   end
   always_comb begin
      dmem_we_o   = state_q == MEM && op == OP_SW;
      in_ready_o  = state_q == IO_WAIT && op == OP_IN;
      out_valid_o = state_q == IO_WAIT && op == OP_OUT;
      halted_o    = state_q == HALT;
      rf_we       = state_q == WB || (in_ready_o && in_valid_i);
      rf_waddr    = op == OP_R ? rd_idx : rt_idx;
      rf_wdata    = state_q == IO_WAIT ? in_data_i : res_q;
   end
   assign imem_addr_o  = pc_q;
   assign dmem_addr_o  = res_q;
   assign dmem_wdata_o = b_q;
   assign out_data_o   = out_q;
   assign illegal_o    = illegal_q;
   always_comb begin
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      out_d     = out_q;
      illegal_d = illegal_q;
      case (state_q)
         FETCH: begin
            ir_d = imem_data_i;
            pc_d = pc_q + PC_W'(1);
         end
         DECODE: begin
            a_d   = rs_val;
            b_d   = rt_val;
            out_d = op == OP_OUT ? rs_val : out_q;
         end
         EXEC: begin
            res_d     = alu;
            pc_d      = op == OP_J ? jump : take ? pc_q + imm_p : pc_q;
            illegal_d = illegal_q | ~legal;
         end
         MEM:     res_d = dmem_rdata_i;
         default: ;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         pc_q      <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         out_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         out_q     <= out_d;
         illegal_q <= illegal_d;
      end
   // register 0 is never written, so it reads as zero after reset
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (rf_we && rf_waddr != '0) begin
         regs_q[rf_waddr] <= rf_wdata;
      end
endmodule

// File: tb/tb_zafx_multicycle_core.sv
// tb_zafx_multicycle_core: directed bench for zafx_multicycle_core
module tb_zafx_multicycle_core;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] imem_addr;
   logic [31:0] imem_data, dmem_addr, dmem_wdata, dmem_rdata, out_data;
   logic [31:0] in_data = '0;
   logic        dmem_we, in_ready, out_valid, halted, illegal;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] rom [0:65535];
   logic [31:0] dmem [0:255];
   int checks = 0, failures = 0, we_cnt = 0, in_cnt = 0, out_cnt = 0, base;

   zafx_multicycle_core dut (
      .clk_i(clk), .rst_ni(rst_n),
      .imem_addr_o(imem_addr), .imem_data_i(imem_data),
      .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_we_o(dmem_we), .dmem_rdata_i(dmem_rdata),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .halted_o(halted), .illegal_o(illegal)
   );

   always #5 clk = ~clk;
   assign imem_data  = rom[imem_addr];
   assign dmem_rdata = dmem[dmem_addr[7:0]];

   always @(posedge clk)
      if (rst_n) begin
         if (dmem_we) begin
            dmem[dmem_addr[7:0]] <= dmem_wdata;
            we_cnt <= we_cnt + 1;
         end
         if (in_ready) in_cnt <= in_cnt + 1;
         if (out_valid && out_ready) out_cnt <= out_cnt + 1;
      end

   function automatic logic [31:0] rty(input int rs, input int rt, input int rd, input int sh, input int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction
   function automatic logic [31:0] ity(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] jty(input int tgt);
      return {6'h02, 26'(tgt)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 65536; i++) rom[i] = 32'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_to_halt(input string tag);
      int n = 0;
      while (!halted && n < 500) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(halted), 32'd1);
   endtask

   initial begin
      // reset aborts ADD mid-EXEC
      clear_rom();
      rom[0] = rty(1, 2, 3, 0, 'h20);
      do_reset();
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_pc", 32'(imem_addr), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
      chk("rst_we", 32'(dmem_we), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rel_pc", 32'(imem_addr), 32'h0);
      tick(1);
      chk("first_fetch", 32'(imem_addr), 32'h1);

      // arithmetic, store/load and cycle count
      clear_rom();
      rom[0]  = ity('h08, 0, 1, 5);
      rom[1]  = ity('h08, 0, 2, -3);
      rom[2]  = rty(1, 2, 3, 0, 'h20);
      rom[3]  = rty(2, 1, 4, 0, 'h2A);
      rom[4]  = ity('h2B, 0, 3, 0);
      rom[5]  = ity('h23, 0, 5, 0);
      rom[6]  = rty(1, 2, 6, 0, 'h22);
      rom[7]  = rty(1, 2, 7, 0, 'h24);
      rom[8]  = rty(1, 2, 8, 0, 'h25);
      rom[9]  = rty(0, 1, 9, 4, 'h00);
      rom[10] = ity('h04, 3, 5, 1);
      rom[11] = ity('h08, 0, 10, 1);
      rom[12] = ity('h08, 0, 11, 2);
      rom[13] = 32'hFC00_0000;
      do_reset();
      base = we_cnt;
      tick(24);
      chk("add_r3", dut.regs_q[3], 32'd2);
      chk("slt_r4", dut.regs_q[4], 32'd1);
      chk("lw_not_yet", dut.regs_q[5], 32'd0);
      chk("sw_mem", dmem[0], 32'd2);
      chk("we_pulses", 32'(we_cnt - base), 32'd1);
      tick(1);
      chk("lw_r5_25cyc", dut.regs_q[5], 32'd2);
      run_to_halt("halt_prog2");
      chk("sub_r6", dut.regs_q[6], 32'd8);
      chk("and_r7", dut.regs_q[7], 32'd5);
      chk("or_r8", dut.regs_q[8], 32'hFFFF_FFFD);
      chk("sll_r9", dut.regs_q[9], 32'd80);
      chk("beq_skip_r10", dut.regs_q[10], 32'd0);
      chk("after_beq_r11", dut.regs_q[11], 32'd2);
      chk("we_total", 32'(we_cnt - base), 32'd1);

      // BNE loop, jump to top of pc space and wrap
      clear_rom();
      rom[0]        = ity('h08, 0, 1, 3);
      rom[1]        = ity('h08, 1, 1, -1);
      rom[2]        = ity('h05, 1, 0, -2);
      rom[3]        = jty('hFFFF);
      rom['hFFFF]   = jty('h0010);
      rom['h0010]   = 32'hFC00_0000;
      do_reset();
      tick(28);
      chk("loop_at_ffff", 32'(imem_addr), 32'hFFFF);
      chk("loop_r1", dut.regs_q[1], 32'd0);
      tick(1);
      chk("pc_wrap", 32'(imem_addr), 32'h0000);
      tick(2);
      chk("jump_0010", 32'(imem_addr), 32'h0010);
      clear_rom();
      rom[0]      = jty('hFFFF);
      rom['hFFFF] = ity('h04, 0, 0, 3);
      do_reset();
      tick(6);
      chk("branch_wrap", 32'(imem_addr), 32'h0003);

      // IN with delayed valid, OUT with delayed ready
      clear_rom();
      rom[0] = ity('h3C, 0, 6, 0);
      rom[1] = ity('h3D, 6, 0, 0);
      rom[2] = 32'hFC00_0000;
      do_reset();
      base = in_cnt;
      tick(2);
      chk("in_ready_up", 32'(in_ready), 32'd1);
      tick(7);
      chk("in_still_wait", 32'(in_ready), 32'd1);
      chk("in_r6_pending", dut.regs_q[6], 32'd0);
      in_valid = 1'b1;
      in_data  = 32'hA5;
      tick(1);
      in_valid = 1'b0;
      in_data  = 32'h0;
      chk("in_ready_cycles", 32'(in_cnt - base), 32'd8);
      chk("in_ready_down", 32'(in_ready), 32'd0);
      chk("in_r6", dut.regs_q[6], 32'hA5);
      base = out_cnt;
      tick(2);
      chk("out_valid_1", 32'(out_valid), 32'd1);
      chk("out_data_1", out_data, 32'hA5);
      tick(1);
      chk("out_valid_2", 32'(out_valid), 32'd1);
      chk("out_data_2", out_data, 32'hA5);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk("out_valid_drop", 32'(out_valid), 32'd0);
      chk("out_handshakes", 32'(out_cnt - base), 32'd1);

      // r0 write discard, illegal opcode, halt freeze
      clear_rom();
      rom[0] = ity('h08, 0, 0, 9);
      rom[1] = 32'hF800_0000;
      rom[2] = 32'hFC00_0000;
      rom[3] = ity('h08, 0, 1, 1);
      do_reset();
      tick(4);
      chk("r0_zero", dut.regs_q[0], 32'd0);
      tick(2);
      chk("illegal_before", 32'(illegal), 32'd0);
      tick(1);
      chk("illegal_set", 32'(illegal), 32'd1);
      tick(1);
      chk("halted_before", 32'(halted), 32'd0);
      tick(1);
      chk("halted_set", 32'(halted), 32'd1);
      chk("halt_pc", 32'(imem_addr), 32'd3);
      tick(100);
      chk("halted_hold", 32'(halted), 32'd1);
      chk("halt_pc_hold", 32'(imem_addr), 32'd3);
      chk("illegal_sticky", 32'(illegal), 32'd1);
      chk("halt_r1", dut.regs_q[1], 32'd0);

      // funct 0x18
      clear_rom();
      rom[0] = ity('h08, 0, 1, 7);
      rom[1] = ity('h08, 0, 2, 6);
      rom[2] = rty(1, 2, 7, 0, 'h18);
      rom[3] = 32'hFC00_0000;
      do_reset();
      run_to_halt("halt_mul");
`ifdef ZAFX_MUL_EN
      chk("mul_rd", dut.regs_q[7], 32'd42);
      chk("mul_illegal", 32'(illegal), 32'd0);
`else
      chk("mul_rd", dut.regs_q[7], 32'd0);
      chk("mul_illegal", 32'(illegal), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
